// File: rtl/dac_spi_out.sv
// dac_spi_out: output stage that serialises one parallel sample per frame
// into a 3-wire serial DAC (SYNC_n / SCLK / DIN, DAC samples DIN on SCLK fall).
// Frame word is {pd_mode, sample, zero pad}, shifted out MSB first.
// One frame in flight at a time; data_ready is high only while idle.
// Optional build macro DAC_SIGN_CONV_EN: data_in is two's complement and its
// MSB is inverted at latch time to produce offset binary.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | sync_n high, sclk high, ready; waits for data_valid
// SHIFT | sync_n low, one bit per 2*CLK_DIV cycles (sclk high then low)
// GAP   | sync_n high, holds off the next accept to honour SYNC_HIGH
module dac_spi_out #(
    parameter int DATA_WIDTH  = 12,
    parameter int FRAME_WIDTH = 16,
    parameter int CLK_DIV     = 2,
    parameter int SYNC_HIGH   = 4
) (
    input  logic                  clk_in,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic [1:0]            pd_mode,
    input  logic                  data_valid,
    output logic                  data_ready,
    output logic                  dac_sync_n,
    output logic                  dac_sclk,
    output logic                  dac_din,
    output logic                  busy,
    output logic                  frame_done
);

    localparam int PAD = FRAME_WIDTH - 2 - DATA_WIDTH;
    localparam int HW  = $clog2(CLK_DIV + 1);
    localparam int BW  = $clog2(FRAME_WIDTH);
    localparam int GW  = $clog2(SYNC_HIGH + 1);

    localparam logic [HW-1:0] HALF_LAST = HW'(CLK_DIV - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(FRAME_WIDTH - 1);
    // GAP covers all but the last sync-high cycle; the final one is spent in
    // IDLE with ready already high, which keeps the accept period at
    // frame length + SYNC_HIGH.
    localparam logic [GW-1:0] GAP_LAST  = GW'((SYNC_HIGH > 1) ? (SYNC_HIGH - 2) : 0);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] GAP   = 2'd2;

    logic [1:0]             state;
    logic [HW-1:0]          half_cnt;
    logic [BW-1:0]          bit_cnt;
    logic [GW-1:0]          gap_cnt;
    logic [FRAME_WIDTH-1:0] shift_reg;
    logic [DATA_WIDTH-1:0]  sample;
    logic [FRAME_WIDTH-1:0] frame_word;

    // Build the frame word from the live inputs; it is only used on the accept edge.
    always_comb begin
        sample = data_in;
`ifdef DAC_SIGN_CONV_EN
        sample[DATA_WIDTH-1] = ~data_in[DATA_WIDTH-1];
`endif
        frame_word = FRAME_WIDTH'({pd_mode, sample}) << PAD;
    end

    // Frame sequencer: accept, shift out bit by bit, then hold sync high.
    always_ff @(posedge clk_in or negedge RST) begin
        if (!RST) begin
            state      <= IDLE;
            half_cnt   <= '0;
            bit_cnt    <= '0;
            gap_cnt    <= '0;
            shift_reg  <= '0;
            dac_sync_n <= 1'b1;
            dac_sclk   <= 1'b1;
            dac_din    <= 1'b0;
            data_ready <= 1'b1;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (data_valid && data_ready) begin
                        // MSB goes straight to the pin; the rest waits in shift_reg.
                        dac_din    <= frame_word[FRAME_WIDTH-1];
                        shift_reg  <= frame_word << 1;
                        dac_sync_n <= 1'b0;
                        dac_sclk   <= 1'b1;
                        data_ready <= 1'b0;
                        busy       <= 1'b1;
                        half_cnt   <= '0;
                        bit_cnt    <= '0;
                        state      <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (half_cnt != HALF_LAST) begin
                        half_cnt <= half_cnt + HW'(1);
                    end else begin
                        half_cnt <= '0;
                        if (dac_sclk) begin
                            dac_sclk <= 1'b0;
                        end else if (bit_cnt != BIT_LAST) begin
                            // din only moves as sclk rises, so it is stable over the fall.
                            bit_cnt   <= bit_cnt + BW'(1);
                            dac_sclk  <= 1'b1;
                            dac_din   <= shift_reg[FRAME_WIDTH-1];
                            shift_reg <= shift_reg << 1;
                        end else begin
                            bit_cnt    <= '0;
                            shift_reg  <= '0;
                            dac_sclk   <= 1'b1;
                            dac_din    <= 1'b0;
                            dac_sync_n <= 1'b1;
                            frame_done <= 1'b1;
                            gap_cnt    <= '0;
                            if (SYNC_HIGH == 1) begin
                                data_ready <= 1'b1;
                                busy       <= 1'b0;
                                state      <= IDLE;
                            end else begin
                                state <= GAP;
                            end
                        end
                    end
                end
                GAP: begin
                    if (gap_cnt == GAP_LAST) begin
                        gap_cnt    <= '0;
                        data_ready <= 1'b1;
                        busy       <= 1'b0;
                        state      <= IDLE;
                    end else begin
                        gap_cnt <= gap_cnt + GW'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dac_spi_out.sv
// Bench for dac_spi_out. Two instances: lane 0 at default timing
// (CLK_DIV=2, SYNC_HIGH=4) and lane 1 at CLK_DIV=1, SYNC_HIGH=1.
// A cycle-level model predicts every pin from "cycles since accept";
// a pin monitor decodes frames off the DAC pins for literal checks.
module tb_dac_spi_out;
    localparam int DW = 12;
    localparam int FW = 16;

`ifdef DAC_SIGN_CONV_EN
    localparam int F_A5C    = 16'h0970;
    localparam int F_001    = 16'h2004;
    localparam int F_FFF    = 16'h1FFC;
    localparam int F_800    = 16'h0000;
    localparam int F_7FF_P0 = 16'h3FFC;
    localparam int F_7FF_P1 = 16'h7FFC;
`else
    localparam int F_A5C    = 16'h2970;
    localparam int F_001    = 16'h0004;
    localparam int F_FFF    = 16'h3FFC;
    localparam int F_800    = 16'h2000;
    localparam int F_7FF_P0 = 16'h1FFC;
    localparam int F_7FF_P1 = 16'h5FFC;
`endif

    logic clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    logic [1:0]         rst_n;
    logic [1:0][DW-1:0] data;
    logic [1:0][1:0]    pd;
    logic [1:0]         valid;
    logic [1:0]         ready, sync_n, sclk, din, busy, fdone;

    dac_spi_out #(.DATA_WIDTH(DW), .FRAME_WIDTH(FW), .CLK_DIV(2), .SYNC_HIGH(4)) u_dut_a (
        .clk_in(clk_in), .RST(rst_n[0]), .data_in(data[0]), .pd_mode(pd[0]),
        .data_valid(valid[0]), .data_ready(ready[0]), .dac_sync_n(sync_n[0]),
        .dac_sclk(sclk[0]), .dac_din(din[0]), .busy(busy[0]), .frame_done(fdone[0]));

    dac_spi_out #(.DATA_WIDTH(DW), .FRAME_WIDTH(FW), .CLK_DIV(1), .SYNC_HIGH(1)) u_dut_b (
        .clk_in(clk_in), .RST(rst_n[1]), .data_in(data[1]), .pd_mode(pd[1]),
        .data_valid(valid[1]), .data_ready(ready[1]), .dac_sync_n(sync_n[1]),
        .dac_sclk(sclk[1]), .dac_din(din[1]), .busy(busy[1]), .frame_done(fdone[1]));

    function automatic int cd_of(int l);
        return (l == 0) ? 2 : 1;
    endfunction

    function automatic int sh_of(int l);
        return (l == 0) ? 4 : 1;
    endfunction

    // Frame word by arithmetic: pd in the top two bits, sample above the pad.
    function automatic logic [FW-1:0] word_of(logic [DW-1:0] d, logic [1:0] p);
        int unsigned s;
        s = d;
`ifdef DAC_SIGN_CONV_EN
        s = (s + 2048) % 4096;
`endif
        return FW'(p * 16384 + s * 4);
    endfunction

    // Expected pins {sync_n, sclk, din, ready, busy, frame_done} when the
    // outputs reflect mm edges after the accept edge (mm < 0: idle).
    function automatic logic [5:0] expect_pins(int mm, logic [FW-1:0] w, int cd, int sh);
        int fb;
        logic s_n, sc, d, r, fd;
        fb  = FW * 2 * cd;
        s_n = 1'b1;
        sc  = 1'b1;
        d   = 1'b0;
        if (mm >= 0 && mm < fb) begin
            s_n = 1'b0;
            sc  = (mm % (2 * cd)) < cd;
            d   = w[FW - 1 - mm / (2 * cd)];
        end
        fd = (mm == fb);
        r  = (mm < 0) || (mm >= fb + sh - 1);
        return {s_n, sc, d, r, !r, fd};
    endfunction

    // Model state per lane.
    int            m [2] = '{-1, -1};
    logic [FW-1:0] mword [2];

    // Pin monitor state per lane.
    logic          prev_sync [2] = '{1'b1, 1'b1};
    logic          prev_sclk [2] = '{1'b1, 1'b1};
    logic [FW-1:0] cap [2];
    logic [FW-1:0] last_frame [2];
    int            nbits [2] = '{0, 0};
    int            last_bits [2] = '{0, 0};
    int            low_len [2] = '{0, 0};
    int            last_low [2] = '{0, 0};
    int            intv [2] = '{0, 0};
    time           t_start [2] = '{0, 0};
    int            fd_cnt [2] = '{0, 0};

    int lane_cmp  = 0;
    int lane_fail = 0;
    int n_cmp     = 0;
    int n_fail    = 0;

    // Model advance on the active edge, using the inputs the DUT samples.
    always @(posedge clk_in) begin
        int t;
        for (int l = 0; l < 2; l++) begin
            t = FW * 2 * cd_of(l) + sh_of(l);
            if (!rst_n[l]) begin
                m[l] = -1;
            end else if ((m[l] < 0 || m[l] >= t - 1) && valid[l]) begin
                m[l]     = 0;
                mword[l] = word_of(data[l], pd[l]);
            end else if (m[l] >= 0 && m[l] < t) begin
                m[l] = m[l] + 1;
            end
        end
    end

    // Per-cycle pin compare and frame decode, away from the active edge.
    always @(negedge clk_in) begin
        logic [5:0] got, req;
        for (int l = 0; l < 2; l++) begin
            req = expect_pins(rst_n[l] ? m[l] : -1, mword[l], cd_of(l), sh_of(l));
            got = {sync_n[l], sclk[l], din[l], ready[l], busy[l], fdone[l]};
            lane_cmp++;
            if (got !== req) begin
                lane_fail++;
                $display("FAIL pins lane%0d t=%0t sync_n/sclk/din/ready/busy/done got %b required %b",
                         l, $time, got, req);
            end
            if (!sync_n[l] && prev_sync[l]) begin
                intv[l]    = int'(($time - t_start[l]) / 10);
                t_start[l] = $time;
                low_len[l] = 0;
                nbits[l]   = 0;
                cap[l]     = '0;
            end
            if (!sync_n[l]) begin
                low_len[l]++;
                if (prev_sclk[l] && !sclk[l]) begin
                    cap[l] = {cap[l][FW-2:0], din[l]};
                    nbits[l]++;
                end
            end
            if (sync_n[l] && !prev_sync[l]) begin
                last_frame[l] = cap[l];
                last_low[l]   = low_len[l];
                last_bits[l]  = nbits[l];
            end
            if (fdone[l]) fd_cnt[l]++;
            prev_sync[l] = sync_n[l];
            prev_sclk[l] = sclk[l];
        end
    end

    task automatic check(string name, int got, int req);
        n_cmp++;
        if (got != req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, got, req);
        end
    endtask

    task automatic tick(int n);
        repeat (n) @(posedge clk_in);
        #2;
    endtask

    initial begin
        int n;
        int fd0;
        rst_n = 2'b11;
        valid = 2'b00;
        data  = '0;
        pd    = '0;
        #1 rst_n = 2'b00;
        tick(3);
        rst_n = 2'b11;
        tick(100);

        // Model pinned to hand-computed words.
        check("model_word_a5c", int'(word_of(12'hA5C, 2'd0)), F_A5C);
        check("model_word_800", int'(word_of(12'h800, 2'd0)), F_800);

        // Idle after reset release.
        for (int l = 0; l < 2; l++) begin
            check("idle_sync_n", int'(sync_n[l]), 1);
            check("idle_sclk", int'(sclk[l]), 1);
            check("idle_din", int'(din[l]), 0);
            check("idle_ready", int'(ready[l]), 1);
            check("idle_busy", int'(busy[l]), 0);
        end

        // Single frame, lane 0.
        fd0 = fd_cnt[0];
        data[0] = 12'hA5C; pd[0] = 2'd0; valid[0] = 1'b1;
        tick(1);
        valid[0] = 1'b0;
        n = 0;
        while (!ready[0] && n < 200) begin
            tick(1);
            n++;
        end
        // ready is set on edge E0+67, so it is seen for the accept at E0+68.
        check("a5c_ready_latency", n, 67);
        check("a5c_frame", int'(last_frame[0]), F_A5C);
        check("a5c_bits", last_bits[0], 16);
        check("a5c_sync_low", last_low[0], 64);
        check("a5c_done_pulses", fd_cnt[0] - fd0, 1);

        // Back-to-back with valid held; data changes while busy must not leak.
        fd0 = fd_cnt[0];
        data[0] = 12'h001; valid[0] = 1'b1;
        tick(1);
        data[0] = 12'hFFF;
        tick(66);
        check("b2b_frame1", int'(last_frame[0]), F_001);
        tick(2);
        data[0] = 12'h555; valid[0] = 1'b0;
        tick(75);
        check("b2b_frame2", int'(last_frame[0]), F_FFF);
        check("b2b_interval", intv[0], 68);
        check("b2b_done_pulses", fd_cnt[0] - fd0, 2);

        // Fast lane: CLK_DIV=1, SYNC_HIGH=1.
        data[1] = 12'h800; pd[1] = 2'd0; valid[1] = 1'b1;
        tick(1);
        tick(33);
        valid[1] = 1'b0;
        tick(40);
        check("fast_frame", int'(last_frame[1]), F_800);
        check("fast_sync_low", last_low[1], 32);
        check("fast_bits", last_bits[1], 16);
        check("fast_interval", intv[1], 33);

        // Reset during bit 5 of a frame.
        data[0] = 12'h3C3; pd[0] = 2'd2; valid[0] = 1'b1;
        tick(1);
        valid[0] = 1'b0;
        tick(21);
        fd0 = fd_cnt[0];
        rst_n[0] = 1'b0;
        #1;
        check("abort_sync_n", int'(sync_n[0]), 1);
        check("abort_sclk", int'(sclk[0]), 1);
        check("abort_ready", int'(ready[0]), 1);
        check("abort_busy", int'(busy[0]), 0);
        tick(2);
        rst_n[0] = 1'b1;
        tick(80);
        check("abort_no_done", fd_cnt[0] - fd0, 0);
        data[0] = 12'h7FF; pd[0] = 2'd1; valid[0] = 1'b1;
        tick(1);
        valid[0] = 1'b0;
        tick(75);
        check("after_abort_frame", int'(last_frame[0]), F_7FF_P1);
        check("after_abort_low", last_low[0], 64);

        // Sign-conversion corner samples on lane 0.
        data[0] = 12'h800; pd[0] = 2'd0; valid[0] = 1'b1;
        tick(1);
        data[0] = 12'h7FF;
        tick(66);
        check("conv_800", int'(last_frame[0]), F_800);
        tick(2);
        valid[0] = 1'b0;
        tick(75);
        check("conv_7ff", int'(last_frame[0]), F_7FF_P0);

        // Random traffic on both lanes against the model.
        for (int c = 0; c < 3000; c++) begin
            for (int l = 0; l < 2; l++) begin
                valid[l] = ($urandom_range(0, 3) != 0);
                data[l]  = DW'($urandom);
                pd[l]    = 2'($urandom);
            end
            tick(1);
        end
        valid = 2'b00;
        tick(80);

        n_cmp  += lane_cmp;
        n_fail += lane_fail;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/dac_spi_out.md
Name: dac_spi_out

Overview:
- Downstream output stage for the modulation chain. Accepts parallel samples (the modulator's wave output) through a valid/ready handshake.
- Serialises each sample into one SPI-style frame for a 3-wire serial DAC (SYNC_n / SCLK / DIN, DAC samples DIN on the SCLK falling edge).
- Drives the DAC pins directly and reports frame completion. One frame in flight at a time, no buffering.

Parameters:
- DATA_WIDTH, 12, sample width; matches the modulator output width.
- FRAME_WIDTH, 16, bits per SPI frame; must be >= DATA_WIDTH + 2.
- CLK_DIV, 2, clk_in cycles per SCLK half-period; must be >= 1.
- SYNC_HIGH, 4, minimum clk_in cycles dac_sync_n stays high between frames; must be >= 1.

Ports:
- clk_in  input  1  system clock; all logic is on its rising edge.
- RST  input  1  asynchronous, active-low reset.
- data_in  input  DATA_WIDTH  sample, unsigned offset-binary.
- pd_mode  input  2  DAC power-down control bits; latched together with data_in.
- data_valid  input  1  sample present.
- data_ready  output  1  block can accept a sample.
- dac_sync_n  output  1  frame sync, active-low.
- dac_sclk  output  1  serial clock, idles high.
- dac_din  output  1  serial data, MSB first.
- busy  output  1  high while a frame or the sync-high gap is in progress.
- frame_done  output  1  one-cycle pulse at frame end.

Behaviour:
- Reset (RST=0, asynchronous): dac_sync_n=1, dac_sclk=1, dac_din=0, data_ready=1, busy=0, frame_done=0. All counters are cleared, the shift register is cleared, and the FSM goes to IDLE.
- Reset asserted mid-frame aborts the frame immediately: sync_n rises and no frame_done pulse is issued.
- All outputs are registered.
- Frame word: {pd_mode, data_in, PAD zeros}, where PAD = FRAME_WIDTH - 2 - DATA_WIDTH. The word is latched on the accept edge, so later changes to data_in or pd_mode do not affect the frame in progress.
- Accept: data_valid & data_ready sampled high on edge E0.
  - data_ready is high only in IDLE.
  - data_valid while not ready is ignored (not queued). Callers hold it.
- FSM states: IDLE -> SHIFT -> GAP -> IDLE.
- IDLE: sync_n=1, sclk=1, ready=1, busy=0.
  - On accept: ready=0 and busy=1 from E0+1.
  - Also from E0+1: sync_n=0, sclk=1, din=frame[FRAME_WIDTH-1].
  - Go to SHIFT.
- SHIFT: each bit occupies 2*CLK_DIV cycles: CLK_DIV cycles with sclk=1, then CLK_DIV cycles with sclk=0.
  - dac_din changes only on the edge where sclk returns high, so it is stable across the falling edge.
  - A bit counter counts 0..FRAME_WIDTH-1; the half-period counter counts 0..CLK_DIV-1.
  - After the low phase of the last bit: sync_n=1, sclk=1, din=0, frame_done=1 for one cycle. Go to GAP.
  - sync_n is low for exactly FRAME_WIDTH*2*CLK_DIV cycles (64 at defaults), i.e. edge E0+1 through E0+64.
- GAP: sync_n high, counts SYNC_HIGH cycles.
  - data_ready=1 and busy=0 from edge E0 + FRAME_WIDTH*2*CLK_DIV + SYNC_HIGH (E0+68 at defaults).
  - Go to IDLE.
- Throughput: with data_valid held high, frames are accepted every FRAME_WIDTH*2*CLK_DIV + SYNC_HIGH cycles (68 at defaults). There are no idle bubbles beyond that.
- Counter wrap: counters reset to 0 at their terminal value. No overflow is possible for any legal parameter set.

Optional Feature:
- Macro: DAC_SIGN_CONV_EN.
- Defined: data_in is two's complement; its MSB is inverted at latch time to produce offset binary (12'h800 -> 12'h000, 12'h7FF -> 12'hFFF).
- Undefined: data_in passes unmodified.
- Timing is identical either way.

Test Plan:
- Reset release, data_valid=0 -> sync_n=1, sclk=1, din=0, ready=1, busy=0; steady for 100 cycles.
- data_in=12'hA5C, pd_mode=0, single accept -> 16 bits captured on SCLK falling edges equal 16'h2970. sync_n is low for 64 cycles, one frame_done pulse, ready high at E0+68.
- data_valid held high, samples 12'h001 then 12'hFFF -> accepts exactly 68 cycles apart; frames 16'h0004 then 16'h3FFC. Sample changes during busy are ignored.
- CLK_DIV=1, SYNC_HIGH=1, data_in=12'h800 -> sync_n low 32 cycles, SCLK period 2 cycles, frame 16'h2000, accept period 33 cycles.
- RST pulsed low at bit 5 of a frame -> sync_n=1, sclk=1, ready=1 immediately, no frame_done pulse. The next accepted frame is complete and correct.
- DAC_SIGN_CONV_EN defined, data_in=12'h800 -> frame 16'h0000; data_in=12'h7FF -> 16'h3FFC.
